// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, function fields, one-hot
// instruction indices and the decoded bundle carried into execute.
package rv32i_pkg;

    localparam int P_XLEN      = 32;
    localparam int P_NUM_INSTR = 37;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD_SUB = 3'd0;
    localparam logic [2:0] F3_SLL     = 3'd1;
    localparam logic [2:0] F3_SLT     = 3'd2;
    localparam logic [2:0] F3_SLTU    = 3'd3;
    localparam logic [2:0] F3_XOR     = 3'd4;
    localparam logic [2:0] F3_SRL_SRA = 3'd5;
    localparam logic [2:0] F3_OR      = 3'd6;
    localparam logic [2:0] F3_AND     = 3'd7;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    localparam logic [5:0] I_ADD   = 6'd0;
    localparam logic [5:0] I_SUB   = 6'd1;
    localparam logic [5:0] I_XOR   = 6'd2;
    localparam logic [5:0] I_OR    = 6'd3;
    localparam logic [5:0] I_AND   = 6'd4;
    localparam logic [5:0] I_SLL   = 6'd5;
    localparam logic [5:0] I_SRL   = 6'd6;
    localparam logic [5:0] I_SRA   = 6'd7;
    localparam logic [5:0] I_SLT   = 6'd8;
    localparam logic [5:0] I_SLTU  = 6'd9;
    localparam logic [5:0] I_ADDI  = 6'd10;
    localparam logic [5:0] I_XORI  = 6'd11;
    localparam logic [5:0] I_ORI   = 6'd12;
    localparam logic [5:0] I_ANDI  = 6'd13;
    localparam logic [5:0] I_SLLI  = 6'd14;
    localparam logic [5:0] I_SRLI  = 6'd15;
    localparam logic [5:0] I_SRAI  = 6'd16;
    localparam logic [5:0] I_SLTI  = 6'd17;
    localparam logic [5:0] I_SLTIU = 6'd18;
    localparam logic [5:0] I_LB    = 6'd19;
    localparam logic [5:0] I_LH    = 6'd20;
    localparam logic [5:0] I_LW    = 6'd21;
    localparam logic [5:0] I_LBU   = 6'd22;
    localparam logic [5:0] I_LHU   = 6'd23;
    localparam logic [5:0] I_SB    = 6'd24;
    localparam logic [5:0] I_SH    = 6'd25;
    localparam logic [5:0] I_SW    = 6'd26;
    localparam logic [5:0] I_BEQ   = 6'd27;
    localparam logic [5:0] I_BNE   = 6'd28;
    localparam logic [5:0] I_BLT   = 6'd29;
    localparam logic [5:0] I_BGE   = 6'd30;
    localparam logic [5:0] I_BLTU  = 6'd31;
    localparam logic [5:0] I_BGEU  = 6'd32;
    localparam logic [5:0] I_JAL   = 6'd33;
    localparam logic [5:0] I_JALR  = 6'd34;
    localparam logic [5:0] I_LUI   = 6'd35;
    localparam logic [5:0] I_AUIPC = 6'd36;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic [P_NUM_INSTR-1:0] instructions;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic [P_XLEN-1:0]      imm;
        logic [P_XLEN-1:0]      pc;
        logic                   illegal;
    } decoded_t;

endpackage

// File: rtl/rv32i_decode_comb.sv
// Purely combinational RV32I decoder: instruction word to one-hot opcode
// vector, register addresses, immediate and illegal flag.
module rv32i_decode_comb
    import rv32i_pkg::*;
(
    input  logic [31:0]            i_instr,
    output logic [P_NUM_INSTR-1:0] o_instructions,
    output logic [4:0]             o_rs1,
    output logic [4:0]             o_rs2,
    output logic [4:0]             o_rd,
    output logic [P_XLEN-1:0]      o_imm,
    output logic                   o_illegal
);

    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [5:0] w_idx;
    logic       w_hit;
    imm_fmt_e   w_fmt;

    assign w_op  = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign o_rs1 = i_instr[19:15];
    assign o_rs2 = i_instr[24:20];
    assign o_rd  = i_instr[11:7];

    always_comb begin
        w_idx = I_ADD;
        w_hit = 1'b0;
        w_fmt = FMT_NONE;
        case (w_op)
            OP: begin
                w_fmt = FMT_R;
                if (w_f7 == F7_BASE) begin
                    w_hit = 1'b1;
                    case (w_f3)
                        F3_ADD_SUB: w_idx = I_ADD;
                        F3_SLL:     w_idx = I_SLL;
                        F3_SLT:     w_idx = I_SLT;
                        F3_SLTU:    w_idx = I_SLTU;
                        F3_XOR:     w_idx = I_XOR;
                        F3_SRL_SRA: w_idx = I_SRL;
                        F3_OR:      w_idx = I_OR;
                        default:    w_idx = I_AND;
                    endcase
                end else if (w_f7 == F7_ALT) begin
                    if (w_f3 == F3_ADD_SUB) begin
                        w_hit = 1'b1;
                        w_idx = I_SUB;
                    end else if (w_f3 == F3_SRL_SRA) begin
                        w_hit = 1'b1;
                        w_idx = I_SRA;
                    end
                end
            end
            OP_IMM: begin
                w_fmt = FMT_I;
                w_hit = 1'b1;
                case (w_f3)
                    F3_ADD_SUB: w_idx = I_ADDI;
                    F3_SLT:     w_idx = I_SLTI;
                    F3_SLTU:    w_idx = I_SLTIU;
                    F3_XOR:     w_idx = I_XORI;
                    F3_OR:      w_idx = I_ORI;
                    F3_AND:     w_idx = I_ANDI;
                    F3_SLL: begin
                        w_fmt = FMT_SH;
                        w_idx = I_SLLI;
                        w_hit = (w_f7 == F7_BASE);
                    end
                    default: begin
                        // shift-right immediates share funct3; imm[11:5] selects logical/arith
                        w_fmt = FMT_SH;
                        w_idx = (w_f7 == F7_ALT) ? I_SRAI : I_SRLI;
                        w_hit = (w_f7 == F7_BASE) || (w_f7 == F7_ALT);
                    end
                endcase
            end
            LOAD: begin
                w_fmt = FMT_I;
                w_hit = 1'b1;
                case (w_f3)
                    F3_B:    w_idx = I_LB;
                    F3_H:    w_idx = I_LH;
                    F3_W:    w_idx = I_LW;
                    F3_BU:   w_idx = I_LBU;
                    F3_HU:   w_idx = I_LHU;
                    default: w_hit = 1'b0;
                endcase
            end
            STORE: begin
                w_fmt = FMT_S;
                w_hit = 1'b1;
                case (w_f3)
                    F3_B:    w_idx = I_SB;
                    F3_H:    w_idx = I_SH;
                    F3_W:    w_idx = I_SW;
                    default: w_hit = 1'b0;
                endcase
            end
            BRANCH: begin
                w_fmt = FMT_B;
                w_hit = 1'b1;
                case (w_f3)
                    F3_BEQ:  w_idx = I_BEQ;
                    F3_BNE:  w_idx = I_BNE;
                    F3_BLT:  w_idx = I_BLT;
                    F3_BGE:  w_idx = I_BGE;
                    F3_BLTU: w_idx = I_BLTU;
                    F3_BGEU: w_idx = I_BGEU;
                    default: w_hit = 1'b0;
                endcase
            end
            JAL: begin
                w_fmt = FMT_J;
                w_hit = 1'b1;
                w_idx = I_JAL;
            end
            JALR: begin
                w_fmt = FMT_I;
                w_hit = (w_f3 == 3'd0);
                w_idx = I_JALR;
            end
            LUI: begin
                w_fmt = FMT_U;
                w_hit = 1'b1;
                w_idx = I_LUI;
            end
            AUIPC: begin
                w_fmt = FMT_U;
                w_hit = 1'b1;
                w_idx = I_AUIPC;
            end
            default: begin
                w_fmt = FMT_NONE;
                w_hit = 1'b0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < P_NUM_INSTR; gi++) begin : g_onehot
            assign o_instructions[gi] = w_hit && (w_idx == 6'(gi));
        end
    endgenerate

    assign o_illegal = !w_hit;

    always_comb begin
        o_imm = '0;
        if (w_hit) begin
            case (w_fmt)
                FMT_I:   o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
                FMT_SH:  o_imm = {27'b0, i_instr[24:20]};
                FMT_S:   o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
                FMT_B:   o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                  i_instr[30:25], i_instr[11:8], 1'b0};
                FMT_U:   o_imm = {i_instr[31:12], 12'h000};
                FMT_J:   o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                  i_instr[20], i_instr[30:21], 1'b0};
                default: o_imm = '0;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Registered RV32I decode stage: decode on the input side, then an output
// register backed by one skid entry so back-pressure never costs throughput.
module rv32i_decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN      = P_XLEN,
    parameter int NUM_INSTR = P_NUM_INSTR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [XLEN-1:0]      in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NUM_INSTR-1:0] out_instructions,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic [4:0]           out_rd,
    output logic [XLEN-1:0]      out_imm,
    output logic [XLEN-1:0]      out_pc,
    output logic                 out_illegal
);

    decoded_t w_dec;
    decoded_t r_out;
    decoded_t r_skid;
    logic     r_out_valid;
    logic     r_skid_valid;
    logic     w_accept;
    logic     w_out_free;

    rv32i_decode_comb u_decode (
        .i_instr        (in_instr),
        .o_instructions (w_dec.instructions),
        .o_rs1          (w_dec.rs1),
        .o_rs2          (w_dec.rs2),
        .o_rd           (w_dec.rd),
        .o_imm          (w_dec.imm),
        .o_illegal      (w_dec.illegal)
    );
    assign w_dec.pc = in_pc;

    // in_ready depends only on skid occupancy, keeping out_ready off the input path
    assign in_ready   = !r_skid_valid;
    assign w_accept   = in_valid && !r_skid_valid && !flush;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) begin
                    r_out <= w_dec;
                end
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid        = r_out_valid;
    assign out_instructions = r_out.instructions;
    assign out_rs1          = r_out.rs1;
    assign out_rs2          = r_out.rs2;
    assign out_rd           = r_out.rd;
    assign out_imm          = r_out.imm;
    assign out_pc           = r_out.pc;
    assign out_illegal      = r_out.illegal;

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Directed checks of the RV32I decode stage: decode table, handshake/skid,
// flush and reset behaviour.
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] out_instructions;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    rv32i_decode_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_instr         (in_instr),
        .in_pc            (in_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instructions (out_instructions),
        .out_rs1          (out_rs1),
        .out_rs2          (out_rs2),
        .out_rd           (out_rd),
        .out_imm          (out_imm),
        .out_pc           (out_pc),
        .out_illegal      (out_illegal)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = 32'h0; in_pc = 32'h0;
        step; step;
        rst = 1'b0;
        $display("reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b exp 1", in_ready); else passed++;
        total++;
        if ({out_instructions, out_rs1, out_rs2, out_rd, out_imm, out_pc, out_illegal} !== '0)
            $display("FAIL reset_fields got instr=%h imm=%h pc=%h ill=%0b exp all zero",
                     out_instructions, out_imm, out_pc, out_illegal);
        else passed++;
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h0;
        step;
        in_valid = 1'b0;
        $display("addi: valid=%0b instr=%h rd=%0d rs1=%0d imm=%h", out_valid, out_instructions, out_rd, out_rs1, out_imm);
        total++; if (out_valid !== 1'b1) $display("FAIL addi_valid got %0b exp 1", out_valid); else passed++;
        total++; if (out_instructions !== 37'h400) $display("FAIL addi_onehot got %h exp %h", out_instructions, 37'h400); else passed++;
        total++;
        if ({out_rd, out_rs1, out_imm, out_illegal} !== {5'd1, 5'd0, 32'd5, 1'b0})
            $display("FAIL addi_fields got rd=%0d rs1=%0d imm=%h ill=%0b exp rd=1 rs1=0 imm=5 ill=0",
                     out_rd, out_rs1, out_imm, out_illegal);
        else passed++;
        step;
        total++; if (out_valid !== 1'b0) $display("FAIL addi_drain got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'h402081B3; in_pc = 32'h10;
        step;
        $display("sub: instr=%h rd=%0d rs1=%0d rs2=%0d", out_instructions, out_rd, out_rs1, out_rs2);
        total++;
        if ({out_valid, out_instructions, out_rd, out_rs1, out_rs2, out_imm} !== {1'b1, 37'h2, 5'd3, 5'd1, 5'd2, 32'd0})
            $display("FAIL b2b_sub got v=%0b instr=%h rd=%0d rs1=%0d rs2=%0d imm=%h exp v=1 instr=2 rd=3 rs1=1 rs2=2 imm=0",
                     out_valid, out_instructions, out_rd, out_rs1, out_rs2, out_imm);
        else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready1 got %0b exp 1", in_ready); else passed++;
        in_instr = 32'h40335293; in_pc = 32'h14;
        step;
        in_valid = 1'b0;
        $display("srai: instr=%h rd=%0d rs1=%0d imm=%h", out_instructions, out_rd, out_rs1, out_imm);
        total++;
        if ({out_valid, out_instructions, out_rd, out_rs1, out_imm, out_pc} !== {1'b1, 37'h10000, 5'd5, 5'd6, 32'd3, 32'h14})
            $display("FAIL b2b_srai got v=%0b instr=%h rd=%0d rs1=%0d imm=%h pc=%h exp v=1 instr=10000 rd=5 rs1=6 imm=3 pc=14",
                     out_valid, out_instructions, out_rd, out_rs1, out_imm, out_pc);
        else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_ready2 got %0b exp 1", in_ready); else passed++;
        step;
    endtask

    task automatic test_branch;
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h100;
        step;
        in_valid = 1'b0;
        $display("beq: instr=%h imm=%h pc=%h", out_instructions, out_imm, out_pc);
        total++; if (out_instructions !== (37'h1 << 27)) $display("FAIL beq_onehot got %h exp %h", out_instructions, 37'h1 << 27); else passed++;
        total++; if (out_imm !== 32'hFFFFFFFC) $display("FAIL beq_imm got %h exp FFFFFFFC", out_imm); else passed++;
        total++; if (out_pc !== 32'h100) $display("FAIL beq_pc got %h exp 100", out_pc); else passed++;
        step;
    endtask

    task automatic test_formats;
        logic [31:0] vin  [6];
        logic [36:0] vhot [6];
        logic [31:0] vimm [6];
        logic [4:0]  vrd  [6];
        vin[0] = 32'h123450B7; vhot[0] = 37'h1 << 35; vimm[0] = 32'h12345000; vrd[0] = 5'd1;  // lui
        vin[1] = 32'h008000EF; vhot[1] = 37'h1 << 33; vimm[1] = 32'h00000008; vrd[1] = 5'd1;  // jal +8
        vin[2] = 32'h0020A623; vhot[2] = 37'h1 << 26; vimm[2] = 32'h0000000C; vrd[2] = 5'd12; // sw
        vin[3] = 32'hFFC0A283; vhot[3] = 37'h1 << 21; vimm[3] = 32'hFFFFFFFC; vrd[3] = 5'd5;  // lw -4
        vin[4] = 32'h00335293; vhot[4] = 37'h1 << 15; vimm[4] = 32'h00000003; vrd[4] = 5'd5;  // srli
        vin[5] = 32'h00008067; vhot[5] = 37'h1 << 34; vimm[5] = 32'h00000000; vrd[5] = 5'd0;  // jalr
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_instr = vin[i]; in_pc = 32'h400 + 32'(i * 4);
            step;
            in_valid = 1'b0;
            $display("fmt%0d: in=%h instr=%h imm=%h rd=%0d", i, vin[i], out_instructions, out_imm, out_rd);
            total++;
            if ({out_valid, out_instructions, out_imm, out_rd, out_illegal} !== {1'b1, vhot[i], vimm[i], vrd[i], 1'b0})
                $display("FAIL fmt%0d got v=%0b instr=%h imm=%h rd=%0d ill=%0b exp instr=%h imm=%h rd=%0d",
                         i, out_valid, out_instructions, out_imm, out_rd, out_illegal, vhot[i], vimm[i], vrd[i]);
            else passed++;
            step;
        end
    endtask

    task automatic test_illegal;
        logic [31:0] vin [4];
        vin[0] = 32'h00000000;
        vin[1] = 32'h02208033;  // funct7 0x01
        vin[2] = 32'h40031293;  // slli with imm[11:5]=0x20
        vin[3] = 32'h00002067;  // jalr funct3=2
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = vin[i]; in_pc = 32'h800;
            step;
            in_valid = 1'b0;
            $display("illegal%0d: in=%h valid=%0b ill=%0b instr=%h", i, vin[i], out_valid, out_illegal, out_instructions);
            total++;
            if ({out_valid, out_illegal, out_instructions} !== {1'b1, 1'b1, 37'h0})
                $display("FAIL illegal%0d got v=%0b ill=%0b instr=%h exp v=1 ill=1 instr=0",
                         i, out_valid, out_illegal, out_instructions);
            else passed++;
            if (i == 1) begin
                total++;
                if ({out_rs1, out_rs2} !== {5'd1, 5'd2})
                    $display("FAIL illegal_regs got rs1=%0d rs2=%0d exp rs1=1 rs2=2", out_rs1, out_rs2);
                else passed++;
            end
            step;
        end
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h200;
        step;
        in_instr = 32'h402081B3; in_pc = 32'h204;
        step;
        $display("stall: out pc=%h in_ready=%0b", out_pc, in_ready);
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got %0b exp 0", in_ready); else passed++;
        in_instr = 32'hFE208EE3; in_pc = 32'h208;
        step;
        $display("stall: out pc=%h instr=%h in_ready=%0b", out_pc, out_instructions, in_ready);
        total++;
        if ({out_valid, out_pc, out_instructions, out_imm} !== {1'b1, 32'h200, 37'h400, 32'd5})
            $display("FAIL stall_hold got v=%0b pc=%h instr=%h imm=%h exp v=1 pc=200 instr=400 imm=5",
                     out_valid, out_pc, out_instructions, out_imm);
        else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready2 got %0b exp 0", in_ready); else passed++;
        out_ready = 1'b1;
        step;
        $display("release1: pc=%h instr=%h", out_pc, out_instructions);
        total++;
        if ({out_valid, out_pc, out_instructions} !== {1'b1, 32'h204, 37'h2})
            $display("FAIL release1 got v=%0b pc=%h instr=%h exp v=1 pc=204 instr=2", out_valid, out_pc, out_instructions);
        else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL release1_ready got %0b exp 1", in_ready); else passed++;
        step;
        in_valid = 1'b0;
        $display("release2: pc=%h instr=%h", out_pc, out_instructions);
        total++;
        if ({out_valid, out_pc, out_instructions} !== {1'b1, 32'h208, 37'h1 << 27})
            $display("FAIL release2 got v=%0b pc=%h instr=%h exp v=1 pc=208 instr=8000000", out_valid, out_pc, out_instructions);
        else passed++;
        step;
        total++; if (out_valid !== 1'b0) $display("FAIL release_empty got %0b exp 0", out_valid); else passed++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
        step;
        in_instr = 32'h402081B3; in_pc = 32'h304;
        step;
        in_instr = 32'hFE208EE3; in_pc = 32'h308; flush = 1'b1;
        step;
        flush = 1'b0; in_valid = 1'b0;
        $display("flush: out_valid=%0b in_ready=%0b", out_valid, in_ready);
        total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b exp 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %0b exp 1", in_ready); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            total++; if (out_valid !== 1'b0) $display("FAIL flush_ghost%0d got %0b exp 0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_rst_mid_stall;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h500;
        step;
        in_instr = 32'h402081B3; in_pc = 32'h504;
        step;
        in_instr = 32'hFE208EE3; in_pc = 32'h508; rst = 1'b1;
        step;
        rst = 1'b0; in_valid = 1'b0;
        $display("rst_stall: out_valid=%0b in_ready=%0b pc=%h", out_valid, in_ready, out_pc);
        total++;
        if ({out_valid, in_ready, out_pc, out_instructions} !== {1'b0, 1'b1, 32'h0, 37'h0})
            $display("FAIL rst_stall got v=%0b rdy=%0b pc=%h instr=%h exp v=0 rdy=1 pc=0 instr=0",
                     out_valid, in_ready, out_pc, out_instructions);
        else passed++;
        out_ready = 1'b1;
        step;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_stall_ghost got %0b exp 0", out_valid); else passed++;
    endtask

    initial begin
        test_reset;
        test_addi;
        test_back_to_back;
        test_branch;
        test_formats;
        test_illegal;
        test_stall;
        test_flush;
        test_rst_mid_stall;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
